// File: rtl/vstu_addrgen.sv
// vstu_addrgen: splits unit-stride vector store requests into AXI INCR bursts and queues them for the store unit
module vstu_addrgen #(
  parameter int unsigned AxiDataWidth = 128,
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned BytesWidth   = 32,
  parameter int unsigned QueueDepth   = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [AxiAddrWidth-1:0] req_addr_i,
  input  logic [BytesWidth-1:0]   req_bytes_i,
  output logic [AxiAddrWidth-1:0] aw_addr_o,
  output logic [7:0]              aw_len_o,
  output logic [2:0]              aw_size_o,
  output logic [1:0]              aw_burst_o,
  output logic                    aw_valid_o,
  input  logic                    aw_ready_i,
  output logic [AxiAddrWidth-1:0] ag_addr_o,
  output logic [2:0]              ag_size_o,
  output logic [7:0]              ag_len_o,
  output logic                    ag_is_load_o,
  output logic                    ag_valid_o,
  input  logic                    ag_ready_i,
  output logic                    busy_o
);
  localparam int unsigned B     = AxiDataWidth / 8;
  localparam int unsigned SizeW = $clog2(B);
  localparam int unsigned W     = BytesWidth + 2;
  localparam int unsigned PtrW  = QueueDepth > 1 ? $clog2(QueueDepth) : 1;
  localparam int unsigned CntW  = $clog2(QueueDepth + 1);
  localparam logic [2:0]  Size  = 3'(SizeW);

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t                  state_q, state_d;
  logic [AxiAddrWidth-1:0] cur_addr_q, pend_addr_q, aligned;
  logic [BytesWidth-1:0]   rem_q, rem_next;
  logic [W-1:0]            off, need, page, beats_np, beats, span, tail, consumed;
  logic [7:0]              len;
  logic                    load, push, pop, slot_free, space;
  logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]         cnt_q;
  logic [AxiAddrWidth-1:0] mem_addr [QueueDepth];
  logic [7:0]              mem_len  [QueueDepth];

  // Next burst geometry: beat alignment, 4 KiB page limit and 256-beat cap
  always_comb begin
    off       = W'(cur_addr_q[SizeW-1:0]);
    aligned   = {cur_addr_q[AxiAddrWidth-1:SizeW], SizeW'(0)};
    need      = (off + W'(rem_q) + W'(B - 1)) >> SizeW;
    page      = (W'(4096) - W'(aligned[11:0])) >> SizeW;
    beats_np  = need < page ? need : page;
    beats     = beats_np > W'(256) ? W'(256) : beats_np;
    span      = beats << SizeW;
    tail      = span - off;
    consumed  = tail < W'(rem_q) ? tail : W'(rem_q);
    len       = 8'(beats - W'(1));
    rem_next  = rem_q - BytesWidth'(consumed);
    push      = aw_valid_o && aw_ready_i;
    pop       = ag_valid_o && ag_ready_i;
    slot_free = !aw_valid_o || aw_ready_i;
    space     = ({1'b0, cnt_q} + (CntW + 1)'(push)) < (CntW + 1)'(QueueDepth);
    load      = state_q == SPLIT && rem_q != '0 && slot_free && space;
  end

  // Request acceptance and return to IDLE once the final burst is loaded
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE)
      state_d = req_valid_i && req_bytes_i != '0 ? SPLIT : IDLE;
    else if (load && rem_next == '0)
      state_d = IDLE;
  end

  // State, running address and remaining byte count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      rem_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid_i) begin
        cur_addr_q <= req_addr_i;
        rem_q      <= req_bytes_i;
      end else if (load) begin
        cur_addr_q <= aligned + AxiAddrWidth'(span);
        rem_q      <= rem_next;
      end
    end
  end

  // AW register holds stable until handshake; reloads on the same edge when possible
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_valid_o  <= 1'b0;
      aw_addr_o   <= '0;
      aw_len_o    <= '0;
      pend_addr_q <= '0;
    end else if (load) begin
      aw_valid_o  <= 1'b1;
      aw_addr_o   <= aligned;
      aw_len_o    <= len;
      pend_addr_q <= cur_addr_q;
    end else if (aw_ready_i) begin
      aw_valid_o <= 1'b0;
    end
  end

  // Queue storage, written on AW handshake
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_addr[wr_ptr_q] <= pend_addr_q;
      mem_len[wr_ptr_q]  <= aw_len_o;
    end
  end

  // Queue pointers and occupancy, wrapping modulo depth
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q == PtrW'(QueueDepth - 1) ? '0 : wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q == PtrW'(QueueDepth - 1) ? '0 : rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CntW'(push) - CntW'(pop);
    end
  end

  assign req_ready_o  = state_q == IDLE;
  assign aw_size_o    = aw_valid_o ? Size : 3'd0;
  assign aw_burst_o   = 2'b01;
  assign ag_valid_o   = cnt_q != '0;
  assign ag_addr_o    = ag_valid_o ? mem_addr[rd_ptr_q] : '0;
  assign ag_len_o     = ag_valid_o ? mem_len[rd_ptr_q] : '0;
  assign ag_size_o    = ag_valid_o ? Size : 3'd0;
  assign ag_is_load_o = 1'b0;
  assign busy_o       = state_q == SPLIT || aw_valid_o || ag_valid_o;
endmodule

// File: doc/vstu_addrgen.md
Name: vstu_addrgen

Overview:
- Upstream address generator for unit-stride vector stores.
- Splits each store request (base address plus total byte count) into AXI INCR bursts. Each burst uses full-width beats, is at most 256 beats long, and never crosses a 4 KiB boundary.
- Drives the AXI AW channel.
- Pushes a matching request entry (addr, size, len, is_load=0) into an in-order queue. The vector store unit consumes that queue to place W beats.

Parameters:
- AxiDataWidth, 128, AXI data width in bits. B = AxiDataWidth/8 bytes per beat; B is a power of two, 8..512.
- AxiAddrWidth, 64, AXI address width.
- BytesWidth, 32, width of the byte-count field.
- QueueDepth, 4, depth of the request queue to the store unit; must be at least 2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  new store request valid
- req_ready_o  out  1  block idle, can accept a request
- req_addr_i  in  AxiAddrWidth  base byte address
- req_bytes_i  in  BytesWidth  total bytes, vl<<vsew
- aw_addr_o  out  AxiAddrWidth  burst start address, beat-aligned
- aw_len_o  out  8  beats-1
- aw_size_o  out  3  log2(B)
- aw_burst_o  out  2  constant INCR (2'b01)
- aw_valid_o  out  1  AW valid
- aw_ready_i  in  1  AW ready
- ag_addr_o  out  AxiAddrWidth  queued burst address (unaligned start for the first burst)
- ag_size_o  out  3  log2(B)
- ag_len_o  out  8  beats-1
- ag_is_load_o  out  1  constant 0
- ag_valid_o  out  1  queue non-empty
- ag_ready_i  in  1  store unit finished the burst (last W beat); pops the queue
- busy_o  out  1  request in progress, or AW pending, or queue non-empty

Behaviour:
- Reset values: all outputs 0, except req_ready_o=1 and aw_burst_o=INCR. The state machine goes to IDLE and the queue is emptied.
- Reset mid-operation discards all in-flight bursts and queue entries.
- States: IDLE and SPLIT.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch cur_addr=req_addr_i and rem=req_bytes_i.
  - If req_bytes_i==0: stay in IDLE; no AW and no queue entry is produced.
  - Otherwise go to SPLIT.
- SPLIT:
  - req_ready_o=0.
  - Return to IDLE on the edge where the last burst is loaded into the AW register. req_ready_o=1 in the following cycle.
- Burst computation (combinational, from cur_addr and rem):
  - off = cur_addr mod B; aligned = cur_addr - off.
  - need = ceil((off+rem)/B).
  - page = (4096 - aligned[11:0])/B.
  - beats = min(need, page, 256); len = beats-1.
  - consumed = min(beats*B - off, rem).
  - Next values: cur_addr = aligned + beats*B; rem -= consumed.
  - All arithmetic is done at BytesWidth+1 bits or wider, so there is no overflow.
- AW register:
  - Load condition: state SPLIT, rem!=0, AW slot free (!aw_valid_o || aw_ready_i), and fifo_cnt + (aw_valid_o&&aw_ready_i) < QueueDepth. Pops are ignored, so there is no ready-to-valid path.
  - On load: aw_addr_o=aligned, aw_len_o=len, aw_valid_o=1. The queue payload is latched with ag_addr=cur_addr.
  - While aw_valid_o && !aw_ready_i, all AW outputs stay stable.
  - A burst can load on the same edge as the previous handshake, so back-to-back AW valid is possible.
  - aw_valid_o clears after a handshake when no load happens.
- Request latency: request accepted on edge N; aw_valid_o is high in cycle N+1 if the queue has space.
- Queue:
  - FIFO; the entry is pushed on the AW handshake.
  - ag_* outputs show the head entry; pop on ag_valid_o && ag_ready_i.
  - Simultaneous push and pop is legal at any occupancy. The reservation rule guarantees a push never meets a full queue.
  - Pop when empty is ignored.
  - Order is strictly preserved; pointers wrap modulo QueueDepth.
- busy_o = (state==SPLIT) || aw_valid_o || ag_valid_o.

Test Plan:
1. B=16, req addr=0x1000, bytes=64 -> one AW: addr 0x1000, len 3, size 4. aw_valid_o is high in the cycle after acceptance. Matching ag entry appears; req_ready_o returns to 1.
2. addr=0x1FF8, bytes=32 -> AW1 addr 0x1FF0 len 0 (ag_addr 0x1FF8), then AW2 addr 0x2000 len 1. Order in the queue is preserved.
3. addr=0x0, bytes=8192 -> two AWs: 0x0 len 255 and 0x1000 len 255 (page and 256-beat limit). Also run AxiDataWidth=64: 0x0 len 255, 0x800 len 255, 0x1000 len 255, 0x1800 len 255.
4. bytes=0 -> accepted; no aw_valid_o and no ag_valid_o; req_ready_o stays 1; busy_o stays 0.
5. QueueDepth=4, ag_ready_i=0, aw_ready_i=1, addr=0, bytes=24576 -> exactly 4 AW handshakes, then aw_valid_o stays 0. Each ag_ready_i pulse releases exactly one further burst; total 6 bursts, in order.
6. aw_ready_i held 0 for 5 cycles -> aw_addr_o and aw_len_o stable and aw_valid_o held. Assert rst_ni=0 mid-request -> all outputs reset values next sample; queue empty.
